// File: rtl/planta_envasado.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : planta_envasado                                            |
// | Description : Bottling-line plant emulator driving the fill/seal         |
// |               controller handshake (feed, fill, seal, eject, count).     |
// |               Optional batch limit enabled by PLANTA_BATCH_LIMIT_EN.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module planta_envasado #(
  parameter int FEED_CYCLES  = 2,
  parameter int EJECT_CYCLES = 1,
  parameter int TIMEOUT      = 8,
  parameter int CNT_W        = 8
`ifdef PLANTA_BATCH_LIMIT_EN
  ,
  parameter int BATCH_SIZE   = 5
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear_fault,
  input  logic             llenando,
  input  logic             sellando,
  input  logic             sealed_done,
  output logic             startfill,
  output logic             productook,
  output logic [CNT_W-1:0] bottle_count,
  output logic             fault,
`ifdef PLANTA_BATCH_LIMIT_EN
  output logic             batch_done,
`endif
  output logic [2:0]       plant_state
);

  localparam int TMR_MAX_FE = (FEED_CYCLES > EJECT_CYCLES) ? FEED_CYCLES : EJECT_CYCLES;
  localparam int TMR_MAX    = (TMR_MAX_FE > TIMEOUT) ? TMR_MAX_FE : TIMEOUT;
  localparam int TMR_W      = $clog2(TMR_MAX);

  localparam logic [TMR_W-1:0] FEED_LAST  = TMR_W'(FEED_CYCLES - 1);
  localparam logic [TMR_W-1:0] EJECT_LAST = TMR_W'(EJECT_CYCLES - 1);
  localparam logic [TMR_W-1:0] WAIT_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FEED     = 3'd1,
    S_REQ_FILL = 3'd2,
    S_FILLING  = 3'd3,
    S_REQ_SEAL = 3'd4,
    S_SEALING  = 3'd5,
    S_EJECT    = 3'd6,
    S_FAULT    = 3'd7
  } state_t;

  state_t             state, state_nx;
  logic [TMR_W-1:0]   timer, timer_nx;
  logic [CNT_W-1:0]   count_nx;
  logic               fault_nx;
  logic               wait_expired;
  logic [CNT_W-1:0]   count_inc;

`ifdef PLANTA_BATCH_LIMIT_EN
  localparam int                 BATCH_W    = $clog2(BATCH_SIZE + 1);
  localparam logic [BATCH_W-1:0] BATCH_FULL = BATCH_W'(BATCH_SIZE);

  logic [BATCH_W-1:0] batch_cnt, batch_cnt_nx;
  logic               batch_done_nx;
  logic               run_q;
  logic               run_rise;

  assign run_rise = run & ~run_q;
`endif

  assign wait_expired = (timer == WAIT_LAST);
  assign count_inc    = (bottle_count == CNT_MAX) ? bottle_count : bottle_count + 1'b1;
  assign plant_state  = state;

  always_comb begin
    state_nx = state;
    timer_nx = timer + 1'b1;
    count_nx = bottle_count;
    fault_nx = fault;
`ifdef PLANTA_BATCH_LIMIT_EN
    batch_cnt_nx  = batch_cnt;
    batch_done_nx = batch_done;
`endif
    case (state)
      S_IDLE: begin
`ifdef PLANTA_BATCH_LIMIT_EN
        if (run_rise) begin
          batch_cnt_nx  = '0;
          batch_done_nx = 1'b0;
        end
        // A finished batch holds the line until run is re-armed
        if (run && !fault && (!batch_done || run_rise)) state_nx = S_FEED;
`else
        if (run && !fault) state_nx = S_FEED;
`endif
      end
      S_FEED: begin
        if (!run)                    state_nx = S_IDLE;
        else if (timer == FEED_LAST) state_nx = S_REQ_FILL;
      end
      S_REQ_FILL: begin
        if (llenando)          state_nx = S_FILLING;
        else if (wait_expired) state_nx = S_FAULT;
      end
      S_FILLING: begin
        if (!llenando)         state_nx = S_REQ_SEAL;
        else if (wait_expired) state_nx = S_FAULT;
      end
      S_REQ_SEAL: begin
        if (sellando)          state_nx = S_SEALING;
        else if (wait_expired) state_nx = S_FAULT;
      end
      S_SEALING: begin
        if (sealed_done) begin
          state_nx = S_EJECT;
          count_nx = count_inc;
`ifdef PLANTA_BATCH_LIMIT_EN
          batch_cnt_nx = batch_cnt + 1'b1;
          if (batch_cnt_nx == BATCH_FULL) batch_done_nx = 1'b1;
`endif
        end else if (wait_expired) begin
          state_nx = S_FAULT;
        end
      end
      S_EJECT: begin
        if (timer == EJECT_LAST) begin
          state_nx = run ? S_FEED : S_IDLE;
`ifdef PLANTA_BATCH_LIMIT_EN
          if (batch_done) state_nx = S_IDLE;
`endif
        end
      end
      S_FAULT: begin
        if (clear_fault) begin
          state_nx = S_IDLE;
          fault_nx = 1'b0;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (state_nx == S_FAULT && state != S_FAULT) fault_nx = 1'b1;
    // Every state entry restarts the shared feed/wait/eject timer
    if (state_nx != state || state == S_IDLE || state == S_FAULT) timer_nx = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      timer        <= '0;
      bottle_count <= '0;
      fault        <= 1'b0;
      startfill    <= 1'b0;
      productook   <= 1'b0;
    end else begin
      state        <= state_nx;
      timer        <= timer_nx;
      bottle_count <= count_nx;
      fault        <= fault_nx;
      startfill    <= (state_nx == S_REQ_FILL);
      productook   <= (state_nx == S_REQ_SEAL);
    end
  end

`ifdef PLANTA_BATCH_LIMIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      batch_cnt  <= '0;
      batch_done <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      batch_cnt  <= batch_cnt_nx;
      batch_done <= batch_done_nx;
      run_q      <= run;
    end
  end
`endif

endmodule
`default_nettype wire
